// File: rtl/audio_sequencer.sv
// Sample sequencer: routes each received sample through the effect (or straight through on bypass) to the DAC.
// Optional macro AUDIO_SEQ_OVERRUN_CNT_EN adds a saturating dropped-sample counter.
module audio_sequencer #(
  parameter int clock_max  = 25_000_000,
  parameter int FX_TIMEOUT = 1024
) (
  input  logic        clk_25mhz,
  input  logic        reset_n,
  input  logic        rx_ready,
  input  logic [15:0] rx_audio,
  input  logic        bypass,
  output logic        fx_start,
  output logic [15:0] fx_audio_in,
  input  logic        fx_done,
  input  logic [15:0] fx_audio_out,
  output logic        dac_start,
  output logic [15:0] dac_data,
  input  logic        dac_busy,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  overrun_cnt,
  output logic        fx_timeout
);

  if (FX_TIMEOUT < 2 || FX_TIMEOUT > 65535 || clock_max < 1) begin : g_bad_param
    $error("audio_sequencer: FX_TIMEOUT must be 2..65535 and clock_max positive");
  end

  localparam logic [15:0] TIMEOUT_LAST = 16'(FX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FX_WAIT,
    DAC_REQ,
    DAC_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sample_q, sample_d;
  logic [15:0] out_q, out_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] fx_audio_in_q, fx_audio_in_d;
  logic [15:0] dac_data_q, dac_data_d;
  logic        fx_start_q, fx_start_d;
  logic        dac_start_q, dac_start_d;
  logic        overrun_q, overrun_d;
  logic        fx_timeout_q, fx_timeout_d;

  always_comb begin
    state_d       = state_q;
    sample_d      = sample_q;
    out_d         = out_q;
    wait_cnt_d    = wait_cnt_q;
    fx_audio_in_d = fx_audio_in_q;
    dac_data_d    = dac_data_q;
    fx_start_d    = 1'b0;
    dac_start_d   = 1'b0;
    fx_timeout_d  = fx_timeout_q;
    overrun_d     = rx_ready && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (rx_ready) begin
          sample_d = rx_audio;
          if (bypass) begin
            out_d   = rx_audio;
            state_d = DAC_REQ;
          end else begin
            fx_start_d    = 1'b1;
            fx_audio_in_d = rx_audio;
            wait_cnt_d    = 16'd0;
            state_d       = FX_WAIT;
          end
        end
      end
      FX_WAIT: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        // A completion arriving on the last allowed cycle still counts as on time.
        if (fx_done) begin
          out_d   = fx_audio_out;
          state_d = DAC_REQ;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          out_d        = sample_q;
          fx_timeout_d = 1'b1;
          state_d      = DAC_REQ;
        end
      end
      DAC_REQ: begin
        if (!dac_busy) begin
          dac_start_d = 1'b1;
          dac_data_d  = out_q;
          state_d     = DAC_WAIT;
        end
      end
      DAC_WAIT: begin
        // The driver may not have raised busy yet in the strobe cycle itself.
        if (!dac_start_q && !dac_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      sample_q      <= 16'd0;
      out_q         <= 16'd0;
      wait_cnt_q    <= 16'd0;
      fx_audio_in_q <= 16'd0;
      dac_data_q    <= 16'd0;
      fx_start_q    <= 1'b0;
      dac_start_q   <= 1'b0;
      overrun_q     <= 1'b0;
      fx_timeout_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_q      <= sample_d;
      out_q         <= out_d;
      wait_cnt_q    <= wait_cnt_d;
      fx_audio_in_q <= fx_audio_in_d;
      dac_data_q    <= dac_data_d;
      fx_start_q    <= fx_start_d;
      dac_start_q   <= dac_start_d;
      overrun_q     <= overrun_d;
      fx_timeout_q  <= fx_timeout_d;
    end
  end

`ifdef AUDIO_SEQ_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      ovr_cnt_q <= 8'd0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`else
  assign overrun_cnt = 8'd0;
`endif

  assign fx_start    = fx_start_q;
  assign fx_audio_in = fx_audio_in_q;
  assign dac_start   = dac_start_q;
  assign dac_data    = dac_data_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign fx_timeout  = fx_timeout_q;

endmodule

// File: doc/audio_sequencer.md
AUDIO_SEQUENCER -- requirements
Module: audio_sequencer

Interface
REQ-001 Parameter clock_max, default 25_000_000, system clock frequency in Hz; informational, used only for documentation and bench timing.
REQ-002 Parameter FX_TIMEOUT, default 1024, maximum clk_25mhz cycles spent waiting for the effect to finish; legal range 2..65535.
REQ-003 clk_25mhz  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_ready  input  1  one-cycle strobe from the SPI receiver: a new sample is valid on rx_audio.
REQ-006 rx_audio  input  16  received sample, valid only while rx_ready=1.
REQ-007 bypass  input  1  1 = route the sample straight to the DAC and skip the effect.
REQ-008 fx_start  output  1  one-cycle strobe that starts the effect on fx_audio_in.
REQ-009 fx_audio_in  output  16  sample presented to the effect; held stable from fx_start until the next accepted sample.
REQ-010 fx_done  input  1  effect finished; fx_audio_out is valid in the same cycle.
REQ-011 fx_audio_out  input  16  processed sample from the effect.
REQ-012 dac_start  output  1  one-cycle strobe that starts a DAC transfer of dac_data.
REQ-013 dac_data  output  16  sample for the DAC; held stable from dac_start until the next dac_start.
REQ-014 dac_busy  input  1  DAC driver transfer in progress; the driver raises it no later than 1 cycle after dac_start.
REQ-015 busy  output  1  1 whenever the state is not IDLE.
REQ-016 overrun  output  1  one-cycle pulse for each dropped sample.
REQ-017 overrun_cnt  output  8  saturating count of dropped samples.
REQ-018 fx_timeout  output  1  sticky flag: the effect timed out at least once.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, FX_WAIT, DAC_REQ, DAC_WAIT.
REQ-020 In IDLE, when rx_ready=1, rx_audio SHALL be latched into the sample register and bypass SHALL be sampled in the same cycle.
REQ-021 On that event, if the sampled bypass=0, the next state SHALL be FX_WAIT and fx_start SHALL be 1 in the next cycle only.
REQ-022 On that event, if the sampled bypass=1, the sample SHALL be copied to the output register and the next state SHALL be DAC_REQ.
REQ-023 In FX_WAIT, a 16-bit wait counter SHALL start at 0 on entry and increment every cycle.
REQ-024 In FX_WAIT, when fx_done=1, fx_audio_out SHALL be latched into the output register and the next state SHALL be DAC_REQ.
REQ-025 In FX_WAIT, when the counter reaches FX_TIMEOUT-1 with fx_done=0, the original sample SHALL go to the output register, fx_timeout SHALL be set, and the next state SHALL be DAC_REQ.
REQ-026 If fx_done and the timeout condition occur in the same cycle, fx_done SHALL win and fx_timeout SHALL not be set.
REQ-027 In DAC_REQ, when dac_busy=0, dac_start SHALL be 1 for the next cycle only, dac_data SHALL load the output register in that same cycle, and the next state SHALL be DAC_WAIT.
REQ-028 In DAC_REQ, while dac_busy=1, the FSM SHALL stay in DAC_REQ.
REQ-029 In DAC_WAIT, the FSM SHALL return to IDLE on the first cycle with dac_busy=0, counted from the cycle after dac_start.
REQ-030 If rx_ready=1 in any state other than IDLE, the sample SHALL be dropped, overrun SHALL pulse 1 the next cycle, and the sequence in progress SHALL be unaffected.
REQ-031 fx_done received outside FX_WAIT SHALL be ignored.
REQ-032 Latency SHALL be as follows:
- bypass path: rx_ready at cycle N gives dac_start at N+2, provided dac_busy=0.
- effect path: fx_start at N+1; fx_done at cycle M gives dac_start at M+2.

Reset
REQ-033 While reset_n=0, the following SHALL hold:
- state=IDLE;
- fx_start, dac_start, overrun, busy and fx_timeout = 0;
- fx_audio_in, dac_data, overrun_cnt and all internal registers = 0.
REQ-034 A reset asserted mid-sequence SHALL abort the sequence immediately with no further strobes; the first accepted sample after release SHALL follow REQ-020.

Configuration
REQ-035 With macro AUDIO_SEQ_OVERRUN_CNT_EN defined, overrun_cnt SHALL increment by 1 on each overrun pulse and saturate at 255.
REQ-036 Without AUDIO_SEQ_OVERRUN_CNT_EN, overrun_cnt SHALL be constant 0, no counter SHALL be synthesised, and the overrun pulse SHALL be unchanged.

Verification
REQ-037 Bypass sample: bypass=1, rx_audio=16'h1234 strobe at cycle N, dac_busy=0 -> dac_start at N+2 with dac_data=16'h1234, and fx_start never asserts.
REQ-038 Effect sample: bypass=0, rx_audio=16'h0100; fx_done at fx_start+5 with fx_audio_out=16'h0200 -> dac_data=16'h0200 and exactly one dac_start.
REQ-039 Timeout: bypass=0, FX_TIMEOUT=8, fx_done held 0 -> fx_timeout=1 and dac_data equals the original sample after 8 FX_WAIT cycles; fx_done asserted on the final cycle instead -> fx_timeout stays 0.
REQ-040 Overrun: 300 rx_ready strobes while in FX_WAIT -> 300 overrun pulses; overrun_cnt=255 with the macro, 0 without it; the current sample completes normally.
REQ-041 DAC back-pressure: dac_busy held 1 for 20 cycles in DAC_REQ -> no dac_start until dac_busy falls, then exactly one dac_start.
REQ-042 Reset mid-operation: reset_n=0 during FX_WAIT -> all outputs 0 immediately; after release, a new sample is accepted and sequenced normally.
